matrix_maxpool: RTL and testbench

- Downstream stage of the convolution engine: reads the FP16 feature map that stage wrote into the dest memory.
- Applies 2x2, stride-2 max pooling with an optional ReLU.
- Writes the pooled map to a second memory region.
- Uses the same start/done and single-port address/readdata memory style as the other matrix engines.

---
 rtl/matrix_pkg.sv | 33 +++
 rtl/fp16_max.sv | 37 +++
 rtl/matrix_maxpool.sv | 190 +++++++++++++++++++
 tb/tb_matrix_maxpool.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/matrix_pkg.sv
// Shared definitions for the matrix engines (convolution, pooling, ...).
// Holds the default bus widths, the FP16 field layout, the FP16 +0
// constant, the common engine state encoding and a small FP16 helper.
// No ports: this file is a package imported by the engine modules.
package matrix_pkg;

  localparam int ADDR_W_DEF = 14;
  localparam int DATA_W_DEF = 16;
  localparam int DIM_W_DEF  = 10;

  // IEEE half precision layout
  localparam int FP16_SIGN    = 15;
  localparam int FP16_EXP_MSB = 14;
  localparam int FP16_EXP_LSB = 10;
  localparam int FP16_MAN_MSB = 9;
  localparam int FP16_MAN_LSB = 0;

  localparam logic [15:0] FP16_POS_ZERO = 16'h0000;

  // Engine state encoding, same names as the convolution engine
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ISSUE   = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_WRITE   = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  function automatic logic fp16_is_neg(input logic [15:0] v);
    return v[FP16_SIGN];
  endfunction

endpackage

// File: rtl/fp16_max.sv
// Combinational two-input FP16 maximum working on raw bit patterns.
// NaNs are not special-cased; they compare like any other pattern.
// +0 beats -0 because the sign decides first.
// Ports:
//   a, b : FP16 operands
//   y    : the larger operand
module fp16_max
  import matrix_pkg::*;
(
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] y
);

  logic        sign_a;
  logic        sign_b;
  logic [14:0] mag_a;
  logic [14:0] mag_b;

  assign sign_a = fp16_is_neg(a);
  assign sign_b = fp16_is_neg(b);
  assign mag_a  = a[FP16_EXP_MSB:FP16_MAN_LSB];
  assign mag_b  = b[FP16_EXP_MSB:FP16_MAN_LSB];

  // Sign-magnitude ordering: for negatives the smaller magnitude is larger
  always_comb begin
    y = a;
    if (sign_a != sign_b) begin
      y = sign_a ? b : a;
    end else if (!sign_a) begin
      y = (mag_a >= mag_b) ? a : b;
    end else begin
      y = (mag_a <= mag_b) ? a : b;
    end
  end

endmodule

// File: rtl/matrix_maxpool.sv
// 2x2 stride-2 FP16 max pooling engine with optional ReLU.
// Reads an H x W row-major map from the source memory, writes the
// floor(H/2) x floor(W/2) pooled map contiguously to the destination.
// Each output takes 6 cycles: 4 address issues, 1 capture, 1 write.
// Ports:
//   clk, reset_n                  : clock, async active-low reset
//   start / done                  : handshake; done high only in IDLE
//   relu_en                       : clamp negative results to +0
//   src_start_address, src_row_size (W), src_col_size (H)
//   src_address / src_readdata    : single-port read, 1-cycle latency
//   dest_start_address            : output base
//   dest_address, dest_writedata, dest_write_en : output write port
module matrix_maxpool
  import matrix_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int DIM_W  = DIM_W_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  output logic              done,
  input  logic              relu_en,
  input  logic [ADDR_W-1:0] src_start_address,
  input  logic [DIM_W-1:0]  src_row_size,
  input  logic [DIM_W-1:0]  src_col_size,
  output logic [ADDR_W-1:0] src_address,
  input  logic [DATA_W-1:0] src_readdata,
  input  logic [ADDR_W-1:0] dest_start_address,
  output logic [ADDR_W-1:0] dest_address,
  output logic [DATA_W-1:0] dest_writedata,
  output logic              dest_write_en
);

  state_t state;
  state_t next_state;

  logic [1:0]        k;
  logic [DIM_W-1:0]  row_size;
  logic [DIM_W-1:0]  ow_last;
  logic [DIM_W-1:0]  oh_last;
  logic [DIM_W-1:0]  c;
  logic [DIM_W-1:0]  r;
  logic [ADDR_W-1:0] row_base;
  logic [ADDR_W-1:0] win_base;
  logic              relu;
  logic [DATA_W-1:0] max_q;
  logic [DATA_W-1:0] fold_out;
  logic [ADDR_W-1:0] pitch;
  logic [ADDR_W-1:0] pitch2;
  logic              last_window;
  logic              too_small;

  fp16_max u_max (
    .a(max_q),
    .b(src_readdata),
    .y(fold_out)
  );

  assign pitch       = ADDR_W'(row_size);
  assign pitch2      = ADDR_W'({row_size, 1'b0});
  assign last_window = (r == oh_last) && (c == ow_last);
  assign too_small   = (src_col_size < DIM_W'(2)) || (src_row_size < DIM_W'(2));

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: begin
        if (start) begin
          next_state = too_small ? ST_DONE : ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (k == 2'd3) begin
          next_state = ST_CAPTURE;
        end
      end
      ST_CAPTURE: next_state = ST_WRITE;
      ST_WRITE:   next_state = last_window ? ST_DONE : ST_ISSUE;
      ST_DONE:    next_state = ST_IDLE;
      default:    next_state = ST_IDLE;
    endcase
  end

  // done is high only while sitting in IDLE; the DONE cycle reads as busy
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      done <= 1'b1;
    end else begin
      done <= (next_state == ST_IDLE);
    end
  end

  // Datapath: latch the job, walk the windows, accumulate the maximum
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      k            <= 2'd0;
      row_size     <= '0;
      ow_last      <= '0;
      oh_last      <= '0;
      c            <= '0;
      r            <= '0;
      row_base     <= '0;
      win_base     <= '0;
      relu         <= 1'b0;
      max_q        <= '0;
      dest_address <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            row_size     <= src_row_size;
            ow_last      <= (src_row_size >> 1) - DIM_W'(1);
            oh_last      <= (src_col_size >> 1) - DIM_W'(1);
            row_base     <= src_start_address;
            win_base     <= src_start_address;
            relu         <= relu_en;
            dest_address <= dest_start_address;
            c            <= '0;
            r            <= '0;
            k            <= 2'd0;
          end
        end
        ST_ISSUE: begin
          k <= k + 2'd1;
          // Readdata now belongs to the address issued in the previous cycle
          if (k == 2'd1) begin
            max_q <= src_readdata;
          end else if (k != 2'd0) begin
            max_q <= fold_out;
          end
        end
        ST_CAPTURE: begin
          max_q <= fold_out;
        end
        ST_WRITE: begin
          k            <= 2'd0;
          dest_address <= dest_address + ADDR_W'(1);
          if (c != ow_last) begin
            c        <= c + DIM_W'(1);
            win_base <= win_base + ADDR_W'(2);
          end else begin
            // Skip two source rows; an odd trailing column is never visited
            c        <= '0;
            r        <= r + DIM_W'(1);
            row_base <= row_base + pitch2;
            win_base <= row_base + pitch2;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Window element addresses: top-left, top-right, bottom-left, bottom-right
  always_comb begin
    src_address = '0;
    if (state == ST_ISSUE) begin
      case (k)
        2'd0:    src_address = win_base;
        2'd1:    src_address = win_base + ADDR_W'(1);
        2'd2:    src_address = win_base + pitch;
        default: src_address = win_base + pitch + ADDR_W'(1);
      endcase
    end
  end

  // Output write port; the data bus idles at zero outside WRITE
  always_comb begin
    dest_write_en  = 1'b0;
    dest_writedata = '0;
    if (state == ST_WRITE) begin
      dest_write_en  = 1'b1;
      dest_writedata = (relu && fp16_is_neg(max_q)) ? FP16_POS_ZERO : max_q;
    end
  end

endmodule

// File: tb/tb_matrix_maxpool.sv
// Directed self-checking bench for matrix_maxpool.
// A registered read memory feeds the engine; a monitor logs every write
// and every source address issued while busy.
module tb_matrix_maxpool;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic        done;
  logic        relu_en;
  logic [13:0] src_start_address;
  logic [9:0]  src_row_size;
  logic [9:0]  src_col_size;
  logic [13:0] src_address;
  logic [15:0] src_readdata;
  logic [13:0] dest_start_address;
  logic [13:0] dest_address;
  logic [15:0] dest_writedata;
  logic        dest_write_en;

  logic [15:0] mem [16384];
  bit          touched [16384];
  logic [13:0] wrAddr [$];
  logic [15:0] wrData [$];
  logic [15:0] expData [$];

  int nChecks = 0;
  int nFails  = 0;
  int busy;

  logic [15:0] fpTab [16] = '{16'h3C00, 16'h4000, 16'h4200, 16'h4400,
                              16'h4500, 16'h4600, 16'h4700, 16'h4800,
                              16'h4880, 16'h4900, 16'h4980, 16'h4A00,
                              16'h4A80, 16'h4B00, 16'h4B80, 16'h4C00};

  matrix_maxpool dut (
    .clk(clk),
    .reset_n(reset_n),
    .start(start),
    .done(done),
    .relu_en(relu_en),
    .src_start_address(src_start_address),
    .src_row_size(src_row_size),
    .src_col_size(src_col_size),
    .src_address(src_address),
    .src_readdata(src_readdata),
    .dest_start_address(dest_start_address),
    .dest_address(dest_address),
    .dest_writedata(dest_writedata),
    .dest_write_en(dest_write_en)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    src_readdata <= mem[src_address];
  end

  always @(posedge clk) begin
    if (dest_write_en) begin
      wrAddr.push_back(dest_address);
      wrData.push_back(dest_writedata);
    end
    if (reset_n && !done) begin
      touched[src_address] = 1'b1;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    if (obs !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic checkWrites(input string tag, input logic [13:0] base);
    checkOutput({tag, "_count"}, wrData.size(), expData.size());
    for (int i = 0; i < expData.size(); i++) begin
      if (i < wrData.size()) begin
        checkOutput($sformatf("%s_addr%0d", tag, i), wrAddr[i], base + 14'(i));
        checkOutput($sformatf("%s_data%0d", tag, i), wrData[i], expData[i]);
      end
    end
  endtask

  // Launch one job, scramble the inputs afterwards, poke start while busy,
  // and count the cycles done stays low.
  task automatic applyStimulus(input int w, input int h, input logic [13:0] sb,
                               input logic [13:0] db, input logic relu,
                               output int cycles);
    wrAddr.delete();
    wrData.delete();
    @(negedge clk);
    src_row_size       = 10'(w);
    src_col_size       = 10'(h);
    src_start_address  = sb;
    dest_start_address = db;
    relu_en            = relu;
    start              = 1'b1;
    @(negedge clk);
    start              = 1'b0;
    src_row_size       = 10'd7;
    src_col_size       = 10'd9;
    src_start_address  = 14'd0;
    dest_start_address = 14'd0;
    relu_en            = ~relu;
    cycles = 0;
    while (!done && cycles < 3000) begin
      cycles++;
      start = (cycles == 3);
      @(negedge clk);
    end
    start = 1'b0;
    checkOutput("done_seen", done, 1'b1);
  endtask

  initial begin
    int n;
    int bad;
    reset_n = 1'b0;
    start = 1'b0;
    relu_en = 1'b0;
    src_start_address = '0;
    src_row_size = '0;
    src_col_size = '0;
    dest_start_address = '0;
    for (int i = 0; i < 16384; i++) begin
      mem[i] = 16'h0000;
      touched[i] = 1'b0;
    end
    repeat (3) @(negedge clk);
    checkOutput("rst_done", done, 1'b1);
    checkOutput("rst_wen", dest_write_en, 1'b0);
    checkOutput("rst_wdata", dest_writedata, 16'h0000);
    checkOutput("rst_saddr", src_address, 14'd0);
    checkOutput("rst_daddr", dest_address, 14'd0);
    reset_n = 1'b1;

    $display("[TB] 4x4 ascending");
    for (int i = 0; i < 16; i++) mem[100 + i] = fpTab[i];
    expData = '{16'h4600, 16'h4800, 16'h4B00, 16'h4C00};
    applyStimulus(4, 4, 14'd100, 14'd2000, 1'b0, busy);
    checkOutput("asc_busy", busy, 25);
    checkWrites("asc", 14'd2000);

    $display("[TB] 4x4 negated");
    for (int i = 0; i < 16; i++) mem[100 + i] = fpTab[i] | 16'h8000;
    expData = '{16'hBC00, 16'hC200, 16'hC880, 16'hC980};
    applyStimulus(4, 4, 14'd100, 14'd2100, 1'b0, busy);
    checkWrites("neg", 14'd2100);
    expData = '{16'h0000, 16'h0000, 16'h0000, 16'h0000};
    applyStimulus(4, 4, 14'd100, 14'd2200, 1'b1, busy);
    checkWrites("relu", 14'd2200);

    $display("[TB] 5x3 odd edges");
    for (int i = 0; i < 15; i++) mem[300 + i] = 16'h1000 + 16'(i);
    for (int i = 10; i < 15; i++) mem[300 + i] = 16'h7B00;
    mem[304] = 16'h7B00;
    mem[309] = 16'h7B00;
    for (int i = 0; i < 16384; i++) touched[i] = 1'b0;
    expData = '{16'h1006, 16'h1008};
    applyStimulus(5, 3, 14'd300, 14'd2300, 1'b0, busy);
    checkWrites("odd", 14'd2300);
    checkOutput("odd_busy", busy, 13);
    bad = 0;
    for (int i = 10; i < 15; i++) if (touched[300 + i]) bad++;
    if (touched[304]) bad++;
    if (touched[309]) bad++;
    checkOutput("odd_untouched", bad, 0);

    $display("[TB] degenerate W=1");
    expData.delete();
    applyStimulus(1, 8, 14'd100, 14'd2400, 1'b0, busy);
    checkWrites("deg", 14'd2400);
    checkOutput("deg_busy", busy, 1);

    $display("[TB] signed zero windows");
    mem[500] = 16'h8000; mem[501] = 16'h0000; mem[502] = 16'hBC00; mem[503] = 16'hC000;
    expData = '{16'h0000};
    applyStimulus(2, 2, 14'd500, 14'd2500, 1'b0, busy);
    checkWrites("zero", 14'd2500);
    mem[510] = 16'hBC00; mem[511] = 16'h8000; mem[512] = 16'hC000; mem[513] = 16'hC400;
    expData = '{16'h8000};
    applyStimulus(2, 2, 14'd510, 14'd2510, 1'b0, busy);
    checkWrites("negzero", 14'd2510);

    $display("[TB] reset mid-run");
    for (int i = 0; i < 16; i++) mem[100 + i] = fpTab[i];
    wrAddr.delete();
    wrData.delete();
    @(negedge clk);
    src_row_size = 10'd4;
    src_col_size = 10'd4;
    src_start_address = 14'd100;
    dest_start_address = 14'd2600;
    relu_en = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (wrData.size() < 1 && n < 200) begin
      n++;
      @(negedge clk);
    end
    checkOutput("abort_first_write", wrData.size(), 1);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    checkOutput("abort_wen", dest_write_en, 1'b0);
    checkOutput("abort_done", done, 1'b1);
    repeat (10) @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("abort_no_more_writes", wrData.size(), 1);
    checkOutput("abort_idle_done", done, 1'b1);
    expData = '{16'h4600, 16'h4800, 16'h4B00, 16'h4C00};
    applyStimulus(4, 4, 14'd100, 14'd2600, 1'b0, busy);
    checkWrites("rerun", 14'd2600);
    checkOutput("rerun_busy", busy, 25);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
